// File: rtl/dp_share_pkg.sv
// Shared types and helpers for the datapath-sharing scheduler.
package dp_share_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  // Width of a requester tag; never narrower than one bit.
  function automatic int tag_width(input int num_req);
    return ($clog2(num_req) < 1) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/dp_share_sched_if.sv
// Bundle of requester, datapath and response signals around the scheduler.
interface dp_share_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int RES_W   = 16
);
  logic [NUM_REQ-1:0]        req_vld;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_rdy;
  logic                      dp_data_in_vld;
  logic [DATA_W-1:0]         dp_data_in;
  logic                      dp_data_out_vld;
  logic [RES_W-1:0]          dp_data_out;
  logic [NUM_REQ-1:0]        rsp_vld;
  logic [RES_W-1:0]          rsp_data;

  // Environment side: requesters plus the shared datapath.
  modport master (
    output req_vld, req_data, dp_data_out_vld, dp_data_out,
    input  req_rdy, dp_data_in_vld, dp_data_in, rsp_vld, rsp_data
  );

  // Scheduler side.
  modport slave (
    input  req_vld, req_data, dp_data_out_vld, dp_data_out,
    output req_rdy, dp_data_in_vld, dp_data_in, rsp_vld, rsp_data
  );
endinterface

// File: rtl/dp_share_tag_fifo.sv
// Tag FIFO remembering the owner of every transaction in flight, in issue order.
module dp_share_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_tag,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head_tag,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  // A pop on an empty FIFO is ignored; a push into a full FIFO only lands if a pop frees a slot.
  assign w_pop_ok   = i_pop && (r_count != '0);
  assign w_push_ok  = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop_ok);
  assign o_head_tag = r_mem[r_rd_ptr];
  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;

  // Storage array, written at the tail; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_tag;
    end
  end

  // Pointers and fill level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/dp_share_sched.sv
// Round-robin scheduler sharing one in-order streaming datapath among several requesters.
module dp_share_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int RES_W   = 16,
  parameter int MAX_OUT = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  dp_share_sched_if.slave bus,
  output logic            o_busy,
  output logic            o_err_unexp
);
  import dp_share_pkg::*;

  localparam int TAG_W = tag_width(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OUT) + 1;

  sched_state_t       r_state;
  sched_state_t       w_state_nxt;
  logic [TAG_W-1:0]   r_rr_ptr;
  logic [TAG_W-1:0]   w_gnt_idx;
  logic [TAG_W-1:0]   w_cand;
  logic [TAG_W-1:0]   w_head_tag;
  logic [NUM_REQ-1:0] w_gnt_vec;
  logic               w_gnt;
  logic               w_pop;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [CNT_W-1:0]   w_cnt;
  logic               r_issue_vld;
  logic [DATA_W-1:0]  r_issue_data;
  logic [NUM_REQ-1:0] r_rsp_vld;
  logic [RES_W-1:0]   r_rsp_data;
  logic               r_err;

  // A result only retires a transaction when one is actually outstanding.
  assign w_pop              = bus.dp_data_out_vld && !w_fifo_empty;
  assign bus.req_rdy        = w_gnt_vec;
  assign bus.dp_data_in_vld = r_issue_vld;
  assign bus.dp_data_in     = r_issue_data;
  assign bus.rsp_vld        = r_rsp_vld;
  assign bus.rsp_data       = r_rsp_data;
  assign o_busy             = (r_state != IDLE) || (w_cnt != '0);
  assign o_err_unexp        = r_err;

  dp_share_tag_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (w_gnt),
    .i_push_tag (w_gnt_idx),
    .i_pop      (w_pop),
    .o_head_tag (w_head_tag),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty),
    .o_count    (w_cnt)
  );

  // Next-state logic: drain only returns to idle once nothing is left in flight.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_en) w_state_nxt = RUN; else w_state_nxt = IDLE;
      RUN:     if (!i_en) w_state_nxt = DRAIN; else w_state_nxt = RUN;
      DRAIN: begin
        if (i_en) w_state_nxt = RUN;
        else if (w_cnt == '0) w_state_nxt = IDLE;
        else w_state_nxt = DRAIN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Round-robin arbiter: search starts one past the last winner; a full tag FIFO blocks all grants.
  always_comb begin
    w_gnt     = 1'b0;
    w_gnt_idx = r_rr_ptr;
    w_gnt_vec = '0;
    w_cand    = '0;
    if ((r_state == RUN) && !w_fifo_full) begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        w_cand = TAG_W'((int'(r_rr_ptr) + i) % NUM_REQ);
        if (!w_gnt && bus.req_vld[w_cand]) begin
          w_gnt     = 1'b1;
          w_gnt_idx = w_cand;
        end else begin
          w_gnt_idx = w_gnt_idx;
        end
      end
      if (w_gnt) w_gnt_vec[w_gnt_idx] = 1'b1;
      else       w_gnt_vec = '0;
    end else begin
      w_gnt = 1'b0;
    end
  end

  // Issue register and arbitration pointer: the granted payload goes to the datapath next cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_issue_vld  <= 1'b0;
      r_issue_data <= '0;
      r_rr_ptr     <= '0;
    end else if (w_gnt) begin
      r_issue_vld  <= 1'b1;
      r_issue_data <= bus.req_data[w_gnt_idx*DATA_W +: DATA_W];
      r_rr_ptr     <= w_gnt_idx;
    end else begin
      r_issue_vld  <= 1'b0;
    end
  end

  // Response register: route each result to the owner at the FIFO head; data holds when idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp_vld  <= '0;
      r_rsp_data <= '0;
    end else if (w_pop) begin
      r_rsp_vld  <= NUM_REQ'(1) << w_head_tag;
      r_rsp_data <= bus.dp_data_out;
    end else begin
      r_rsp_vld  <= '0;
    end
  end

  // Sticky flag for a result that arrives with nothing outstanding.
  always_ff @(posedge i_clk) begin
    if (i_rst)                                    r_err <= 1'b0;
    else if (bus.dp_data_out_vld && w_fifo_empty) r_err <= 1'b1;
    else                                          r_err <= r_err;
  end
endmodule

// File: tb/tb_dp_share_sched.sv
// Self-checking bench for dp_share_sched with an echo datapath model and a transaction-level reference.
module tb_dp_share_sched;
  localparam int NR = 4;
  localparam int DW = 16;
  localparam int MO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, busy, err;
  logic [NR-1:0] req_vld;
  logic [NR*DW-1:0] req_data;
  logic          dp_stall, inj_vld, m_vld;
  logic [DW-1:0] inj_data, m_data;
  int            dp_lat;
  int            n_chk = 0;
  int            n_pass = 0;

  dp_share_sched_if #(.NUM_REQ(NR), .DATA_W(DW), .RES_W(DW)) bus ();

  assign bus.req_vld         = req_vld;
  assign bus.req_data        = req_data;
  assign bus.dp_data_out_vld = m_vld | inj_vld;
  assign bus.dp_data_out     = inj_vld ? inj_data : m_data;

  dp_share_sched #(.NUM_REQ(NR), .DATA_W(DW), .RES_W(DW), .MAX_OUT(MO)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .bus(bus), .o_busy(busy), .o_err_unexp(err)
  );

  // Echo datapath: in order, each payload returns no earlier than dp_lat cycles after issue.
  typedef struct { logic [DW-1:0] data; int due; } dp_item_t;
  dp_item_t dpq[$];
  int cyc = 0;
  initial begin
    m_vld = 1'b0;
    m_data = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        dpq.delete();
        m_vld <= 1'b0;
      end else begin
        if (bus.dp_data_in_vld) dpq.push_back('{data: bus.dp_data_in, due: cyc + dp_lat - 1});
        if (!dp_stall && dpq.size() > 0 && dpq[0].due <= cyc) begin
          m_vld  <= 1'b1;
          m_data <= dpq[0].data;
          void'(dpq.pop_front());
        end else begin
          m_vld <= 1'b0;
        end
      end
      cyc++;
    end
  end

  // Reference: scheduler as queues of owners plus 'running'/'active' flags from the en history.
  int            tagq[$];
  bit            m_run, m_active, m_iv, m_err;
  int            m_ptr;
  logic [DW-1:0] m_id, m_rd;
  logic [NR-1:0] m_rv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic m_reset();
    m_run = 0; m_active = 0; m_ptr = 0; tagq.delete();
    m_iv = 0; m_id = '0; m_rv = '0; m_rd = '0; m_err = 0;
  endtask

  // Compare every output against the reference at mid-cycle, then advance the reference.
  task automatic eval();
    int g, k, sz, h;
    logic [NR-1:0] e_rdy;
    @(negedge clk);
    g = -1;
    e_rdy = '0;
    if (m_run && tagq.size() < MO) begin
      for (int i = 1; i <= NR; i++) begin
        k = (m_ptr + i) % NR;
        if (g < 0 && req_vld[k]) g = k;
      end
    end
    if (g >= 0) e_rdy[g] = 1'b1;
    chk("req_rdy", 32'(bus.req_rdy), 32'(e_rdy));
    chk("dp_in_vld", 32'(bus.dp_data_in_vld), 32'(m_iv));
    chk("dp_in", 32'(bus.dp_data_in), 32'(m_id));
    chk("rsp_vld", 32'(bus.rsp_vld), 32'(m_rv));
    chk("rsp_data", 32'(bus.rsp_data), 32'(m_rd));
    chk("busy", 32'(busy), 32'(m_active || tagq.size() != 0));
    chk("err_unexp", 32'(err), 32'(m_err));
    if (rst) begin
      m_reset();
    end else begin
      sz = tagq.size();
      if (bus.dp_data_out_vld && sz > 0) begin
        h = tagq.pop_front();
        m_rv = '0;
        m_rv[h] = 1'b1;
        m_rd = bus.dp_data_out;
      end else begin
        m_rv = '0;
        if (bus.dp_data_out_vld) m_err = 1;
      end
      if (g >= 0) begin
        tagq.push_back(g);
        m_ptr = g;
        m_iv = 1;
        m_id = req_data[g*DW +: DW];
      end else begin
        m_iv = 0;
      end
      m_active = en || (m_active && (m_run || sz != 0));
      m_run = en;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin eval(); adv(); end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; req_vld = '0; inj_vld = 1'b0;
    eval(); adv();
    rst = 1'b0;
  endtask

  task automatic drain();
    en = 1'b0; req_vld = '0; dp_stall = 1'b0; inj_vld = 1'b0;
    step(40);
    eval(); chk("drain_busy", 32'(busy), 32'd0); adv();
  endtask

  typedef struct { logic en; logic [NR-1:0] req; logic [NR-1:0] exp_rdy; } vec_t;
  vec_t tbl[11];

  initial begin
    int n;
    int oc[NR];
    logic [NR-1:0] exp_g;

    tbl[0]  = '{1'b1, 4'b1111, 4'b0000};
    tbl[1]  = '{1'b1, 4'b1111, 4'b0010};
    tbl[2]  = '{1'b1, 4'b1111, 4'b0100};
    tbl[3]  = '{1'b1, 4'b0001, 4'b0001};
    tbl[4]  = '{1'b1, 4'b0001, 4'b0001};
    tbl[5]  = '{1'b1, 4'b1000, 4'b1000};
    tbl[6]  = '{1'b1, 4'b0000, 4'b0000};
    tbl[7]  = '{1'b1, 4'b1010, 4'b0010};
    tbl[8]  = '{1'b1, 4'b1010, 4'b1000};
    tbl[9]  = '{1'b0, 4'b0110, 4'b0010};
    tbl[10] = '{1'b0, 4'b0110, 4'b0000};

    rst = 1'b1; en = 1'b0; req_vld = '0; req_data = '0;
    dp_stall = 1'b0; inj_vld = 1'b0; inj_data = '0; dp_lat = 3;
    @(posedge clk); #1;
    m_reset();
    rst = 1'b0;

    // Directed arbitration table, datapath held off.
    dp_stall = 1'b1;
    for (int i = 0; i < 11; i++) begin
      en = tbl[i].en; req_vld = tbl[i].req; req_data = {$urandom, $urandom};
      eval(); chk($sformatf("tbl%0d_rdy", i), 32'(bus.req_rdy), 32'(tbl[i].exp_rdy)); adv();
    end
    drain();

    // Single request, 3-cycle echo.
    do_reset();
    en = 1'b1; step(1);
    req_vld = 4'b0001; req_data = '0; req_data[15:0] = 16'h00A5;
    eval(); chk("t1_rdy", 32'(bus.req_rdy), 32'h1); adv();
    req_vld = '0;
    eval(); chk("t1_in_vld", 32'(bus.dp_data_in_vld), 32'h1); chk("t1_in", 32'(bus.dp_data_in), 32'h00A5); adv();
    step(3);
    eval(); chk("t1_rsp_vld", 32'(bus.rsp_vld), 32'h1); chk("t1_rsp", 32'(bus.rsp_data), 32'h00A5); adv();

    // All requesting for 8 cycles: strict rotation, two results per owner.
    for (int k = 0; k < NR; k++) oc[k] = 0;
    for (int i = 0; i < 8; i++) begin
      req_vld = 4'b1111; req_data = {$urandom, $urandom};
      exp_g = 4'b0001 << ((i + 1) % NR);
      eval(); chk("t2_order", 32'(bus.req_rdy), 32'(exp_g));
      for (int k = 0; k < NR; k++) if (bus.rsp_vld[k]) oc[k]++;
      adv();
    end
    req_vld = '0;
    for (int i = 0; i < 12; i++) begin
      eval();
      for (int k = 0; k < NR; k++) if (bus.rsp_vld[k]) oc[k]++;
      adv();
    end
    for (int k = 0; k < NR; k++) chk($sformatf("t2_owner%0d_cnt", k), 32'(oc[k]), 32'd2);

    // Stalled datapath: exactly MAX_OUT grants, then one result frees exactly one grant.
    dp_stall = 1'b1; n = 0;
    for (int i = 0; i < 12; i++) begin
      req_vld = 4'b1111; req_data = {$urandom, $urandom};
      eval(); if (bus.req_rdy != '0) n++; adv();
    end
    chk("t3_grants", 32'(n), 32'd8);
    eval(); chk("t3_full_rdy", 32'(bus.req_rdy), 32'd0); adv();
    dp_stall = 1'b0;
    eval(); adv();
    dp_stall = 1'b1;
    eval(); chk("t3_pop_no_bypass", 32'(bus.req_rdy), 32'd0); adv();
    eval(); chk("t3_freed_grant", 32'(bus.req_rdy), 32'h2); adv();
    eval(); chk("t3_full_again", 32'(bus.req_rdy), 32'd0); adv();
    drain();

    // Drain with 5 in flight.
    en = 1'b1; dp_stall = 1'b1; step(1);
    req_vld = 4'b1111;
    for (int i = 0; i < 5; i++) begin req_data = {$urandom, $urandom}; step(1); end
    en = 1'b0; req_vld = '0; step(1);
    req_vld = 4'b1111; dp_stall = 1'b0; n = 0;
    for (int i = 0; i < 30 && n < 5; i++) begin
      eval();
      chk("t4_no_rdy", 32'(bus.req_rdy), 32'd0);
      chk("t4_busy", 32'(busy), 32'd1);
      if (bus.rsp_vld != '0) n++;
      adv();
    end
    chk("t4_rsp_count", 32'(n), 32'd5);
    eval(); chk("t4_idle", 32'(busy), 32'd0); adv();
    req_vld = '0;

    // Unexpected result while idle.
    inj_vld = 1'b1; inj_data = 16'h1234;
    eval(); adv();
    inj_vld = 1'b0;
    eval(); chk("t5_no_rsp", 32'(bus.rsp_vld), 32'd0); chk("t5_err", 32'(err), 32'd1); adv();
    for (int i = 0; i < 3; i++) begin eval(); chk("t5_err_sticky", 32'(err), 32'd1); adv(); end

    // Reset with 3 in flight; arbitration restarts from requester 1.
    en = 1'b1; dp_stall = 1'b1; step(1);
    req_vld = 4'b1100;
    for (int i = 0; i < 3; i++) begin req_data = {$urandom, $urandom}; step(1); end
    do_reset();
    eval();
    chk("t6_rdy", 32'(bus.req_rdy), 32'd0); chk("t6_in_vld", 32'(bus.dp_data_in_vld), 32'd0);
    chk("t6_in", 32'(bus.dp_data_in), 32'd0); chk("t6_rsp_vld", 32'(bus.rsp_vld), 32'd0);
    chk("t6_rsp", 32'(bus.rsp_data), 32'd0); chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_err", 32'(err), 32'd0);
    adv();
    en = 1'b1; dp_stall = 1'b0; step(1);
    req_vld = 4'b1111;
    eval(); chk("t6_first_grant", 32'(bus.req_rdy), 32'h2); adv();
    drain();

    // Randomized traffic against the reference.
    for (int i = 0; i < 1500; i++) begin
      dp_lat   = (i < 750) ? 1 : 5;
      rst      = ($urandom_range(0, 299) == 0);
      en       = ($urandom_range(0, 15) != 0);
      req_vld  = NR'($urandom);
      req_data = {$urandom, $urandom};
      dp_stall = ($urandom_range(0, 3) == 0);
      inj_vld  = ($urandom_range(0, 79) == 0);
      inj_data = DW'($urandom);
      eval(); adv();
    end
    rst = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
